// File: rtl/pending_req_server.sv
// Sticky pending-request vector served highest-index-first
// through a valid/ready offer port, one handshake per two cycles.
module pending_req_server #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             flush,
  input  logic             idx_ready,
  output logic             idx_valid,
  output logic [IDXW-1:0]  idx,
  output logic [WIDTH-1:0] pending,
  output logic [7:0]       served_cnt,
  output logic             collision
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             hs;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] pend_nx;
  logic [IDXW-1:0]  top_idx;
  logic [IDXW-1:0]  idx_nx;
  logic             col_nx;
  logic [7:0]       cnt_nx;

  assign idx_valid = (state == OFFER);
  assign hs        = idx_valid & idx_ready;
  assign clr_mask  = hs ? (WIDTH'(1) << idx) : '0;

  // Highest set bit wins; ascending scan leaves it last.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) top_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            state_nx = OFFER;
            idx_nx   = top_idx;
          end
        end
        OFFER: begin
          if (idx_ready) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // A same-cycle req on the bit being cleared re-arms it.
  always_comb begin
    pend_nx = '0;
    col_nx  = 1'b0;
    if (!flush) begin
      pend_nx = (pending & ~clr_mask) | req;
      col_nx  = collision
              | (|(req & pending & ~clr_mask));
    end
    cnt_nx = served_cnt + 8'(hs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= '0;
      served_cnt <= '0;
      collision  <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      pending    <= pend_nx;
      served_cnt <= cnt_nx;
      collision  <= col_nx;
    end
  end

endmodule

// File: tb/tb_pending_req_server.sv
// Directed scenarios plus random traffic against a
// behavioural model of the pending-request server.
module tb_pending_req_server;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       flush;
  logic       idx_ready;
  logic       idx_valid;
  logic [2:0] idx;
  logic [7:0] pending;
  logic [7:0] served_cnt;
  logic       collision;

  pending_req_server #(.WIDTH(8), .IDXW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flush      (flush),
    .idx_ready  (idx_ready),
    .idx_valid  (idx_valid),
    .idx        (idx),
    .pending    (pending),
    .served_cnt (served_cnt),
    .collision  (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: set of waiting requests, current offer, counters.
  bit [7:0] m_pend;
  bit       m_busy;
  int       m_idx;
  int       m_cnt;
  bit       m_col;

  int passed;
  int total;
  int seen[$];

  function automatic int msb(bit [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_busy = 1'b0;
    m_idx  = 0;
    m_cnt  = 0;
    m_col  = 1'b0;
  endtask

  task automatic model_edge();
    bit       served;
    bit [7:0] done;
    served = m_busy && idx_ready;
    done   = served ? 8'(1 << m_idx) : 8'h00;
    if (served) m_cnt = (m_cnt + 1) % 256;
    if (flush) begin
      m_pend = '0;
      m_busy = 1'b0;
      m_col  = 1'b0;
    end else begin
      if ((req & m_pend & ~done) != 0) m_col = 1'b1;
      if (m_busy) begin
        if (served) m_busy = 1'b0;
      end else if (m_pend != 0) begin
        m_busy = 1'b1;
        m_idx  = msb(m_pend);
      end
      m_pend = (m_pend & ~done) | req;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h expected=%0h",
                tag, got, exp);
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".valid"}, 32'(idx_valid), 32'(m_busy));
    chk({tag, ".idx"}, 32'(idx), 32'(m_idx));
    chk({tag, ".pend"}, 32'(pending), 32'(m_pend));
    chk({tag, ".cnt"}, 32'(served_cnt), 32'(m_cnt));
    chk({tag, ".col"}, 32'(collision), 32'(m_col));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    req       = '0;
    flush     = 1'b0;
    idx_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("reset");
    rst = 1'b0;

    // Scenario 1: three bits served 6,3,2.
    idx_ready = 1'b1;
    req = 8'b0100_1100;
    step("s1");
    req = '0;
    seen.delete();
    for (int i = 0; i < 7; i++) begin
      step("s1");
      if (idx_valid) seen.push_back(int'(idx));
    end
    chk("s1.n", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("s1.o0", 32'(seen[0]), 32'd6);
      chk("s1.o1", 32'(seen[1]), 32'd3);
      chk("s1.o2", 32'(seen[2]), 32'd2);
    end
    chk("s1.cnt", 32'(served_cnt), 32'd3);
    chk("s1.pend", 32'(pending), 32'd0);

    // Scenario 2: no preemption by bit 7.
    idx_ready = 1'b0;
    req = 8'b0000_1011;
    step("s2");
    req = '0;
    step("s2");
    req = 8'b1000_0000;
    step("s2");
    req = '0;
    for (int i = 0; i < 3; i++) begin
      step("s2");
      chk("s2.hold", 32'(idx), 32'd3);
    end
    idx_ready = 1'b1;
    seen.delete();
    seen.push_back(int'(idx));
    for (int i = 0; i < 7; i++) begin
      step("s2");
      if (idx_valid) seen.push_back(int'(idx));
    end
    chk("s2.n", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("s2.o1", 32'(seen[1]), 32'd7);
      chk("s2.o2", 32'(seen[2]), 32'd1);
      chk("s2.o3", 32'(seen[3]), 32'd0);
    end

    // Scenario 3: re-request on the handshake cycle.
    req = 8'h01;
    step("s3");
    req = '0;
    step("s3");
    chk("s3.offer", 32'(idx_valid), 32'd1);
    req = 8'h01;
    step("s3");
    chk("s3.pend", 32'(pending), 32'h01);
    req = '0;
    step("s3");
    chk("s3.again", 32'({idx_valid, idx}), 32'h8);
    chk("s3.col", 32'(collision), 32'd0);
    step("s3");

    // Scenario 4: collision, then flush.
    idx_ready = 1'b0;
    req = 8'h10;
    step("s4");
    step("s4");
    step("s4");
    req = '0;
    chk("s4.col", 32'(collision), 32'd1);
    flush = 1'b1;
    step("s4");
    flush = 1'b0;
    chk("s4.flush",
        32'({pending, collision, idx_valid}), 32'd0);

    // Scenario 5: async reset mid-offer.
    req = 8'h04;
    step("s5");
    req = '0;
    step("s5");
    chk("s5.pre", 32'(idx_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all("s5.async");
    @(negedge clk);
    #2 rst = 1'b0;
    req = 8'h20;
    step("s5");
    chk("s5.e1", 32'(idx_valid), 32'd0);
    req = '0;
    step("s5");
    chk("s5.e2", 32'({idx_valid, idx}), 32'hd);

    // Scenario 6: served_cnt wraps after 256 handshakes.
    idx_ready = 1'b1;
    step("s6");
    for (int n = 1; n < 256; n++) begin
      req = 8'(1 << $urandom_range(7, 0));
      step("s6");
      req = '0;
      step("s6");
      step("s6");
    end
    chk("s6.wrap", 32'(served_cnt), 32'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      req = ($urandom_range(3, 0) == 0)
          ? 8'($urandom) : 8'h00;
      idx_ready = 1'($urandom);
      flush = ($urandom_range(40, 0) == 0);
      step("rnd");
    end
    req = '0;
    flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
